// File: rtl/doa_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doa_sequencer : frame-level controller for FFT -> detect -> weighting -> FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
module doa_sequencer #(
  parameter int TIMEOUT    = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_ready,
  output logic        fft_start,
  input  logic        fft_done,
  output logic        detect_start,
  output logic        detect_done,
  input  logic [9:0]  maxbin_in,
  input  logic        maxbin_valid,
  output logic [9:0]  maxbin,
  input  logic        wb_done,
  input  logic [7:0]  wb_doa,
  input  logic        rd_en,
  output logic [17:0] rd_data,
  output logic        fifo_empty,
  output logic [4:0]  fifo_count,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_overflow,
  input  logic        clr_err
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
  localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_FFT        = 3'd2,
    S_DETECT     = 3'd3,
    S_WEIGHT     = 3'd4,
    S_PUSH       = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               fft_start_q, fft_start_d;
  logic               detect_start_q, detect_start_d;
  logic               detect_done_q, detect_done_d;
  logic [9:0]         maxbin_q, maxbin_d;
  logic [7:0]         doa_q, doa_d;
  logic [15:0]        wdog_q, wdog_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_overflow_q, err_overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic [17:0]        mem_q [FIFO_DEPTH];
  logic [17:0]        mem_d [FIFO_DEPTH];

  logic   timeout_hit;
  logic   push;
  logic   pop;
  logic   wr;
  logic   overflow_hit;
  logic   wdog_expired;
  state_t resume_state;

  always_comb begin
    state_d        = state_q;
    fft_start_d    = 1'b0;
    detect_start_d = 1'b0;
    detect_done_d  = detect_done_q;
    maxbin_d       = maxbin_q;
    doa_d          = doa_q;
    timeout_hit    = 1'b0;
    push           = 1'b0;
    wdog_expired   = (wdog_q == WDOG_LAST);
    resume_state   = enable ? S_WAIT_FRAME : S_IDLE;

    // Completion events are tested before the watchdog so they win a tie.
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (frame_ready) begin
          state_d     = S_FFT;
          fft_start_d = 1'b1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_FFT: begin
        if (fft_done) begin
          state_d        = S_DETECT;
          detect_start_d = 1'b1;
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_d     = resume_state;
        end
      end
      S_DETECT: begin
        if (maxbin_valid) begin
          maxbin_d      = maxbin_in;
          detect_done_d = 1'b1;
          state_d       = S_WEIGHT;
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_d     = resume_state;
        end
      end
      S_WEIGHT: begin
        if (wb_done) begin
          doa_d         = wb_doa;
          detect_done_d = 1'b0;
          state_d       = S_PUSH;
        end else if (wdog_expired) begin
          timeout_hit   = 1'b1;
          detect_done_d = 1'b0;
          state_d       = resume_state;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = resume_state;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts whenever a timed state is entered afresh.
    wdog_d = '0;
    if ((state_q == S_FFT || state_q == S_DETECT || state_q == S_WEIGHT) &&
        (state_d == state_q))
      wdog_d = wdog_q + 16'd1;
  end

  always_comb begin
    pop          = rd_en && (count_q != 5'd0);
    wr           = push && ((count_q != DEPTH_C) || pop);
    overflow_hit = push && (count_q == DEPTH_C) && !pop;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (wr) begin
      mem_d[wr_ptr_q] = {doa_q, maxbin_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr && !pop)      count_d = count_q + 5'd1;
    else if (!wr && pop) count_d = count_q - 5'd1;

    err_timeout_d  = clr_err ? 1'b0 : err_timeout_q;
    err_overflow_d = clr_err ? 1'b0 : err_overflow_q;
    if (timeout_hit)  err_timeout_d  = 1'b1;
    if (overflow_hit) err_overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      fft_start_q    <= 1'b0;
      detect_start_q <= 1'b0;
      detect_done_q  <= 1'b0;
      maxbin_q       <= '0;
      doa_q          <= '0;
      wdog_q         <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mem_q          <= '{default: '0};
    end else begin
      state_q        <= state_d;
      fft_start_q    <= fft_start_d;
      detect_start_q <= detect_start_d;
      detect_done_q  <= detect_done_d;
      maxbin_q       <= maxbin_d;
      doa_q          <= doa_d;
      wdog_q         <= wdog_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_q          <= mem_d;
    end
  end

  assign fft_start    = fft_start_q;
  assign detect_start = detect_start_q;
  assign detect_done  = detect_done_q;
  assign maxbin       = maxbin_q;
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;
  assign fifo_count   = count_q;
  assign fifo_empty   = (count_q == 5'd0);
  assign rd_data      = (count_q == 5'd0) ? 18'd0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: doc/doa_sequencer.md
DOA_SEQUENCER -- requirements
Module: doa_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 4096, watchdog limit in clk cycles per wait state (range 2..65535).
REQ-002 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, 2..16).
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  level; 1 = run frames continuously, 0 = stop after current frame.
REQ-006 frame_ready  in  1  one-cycle pulse; capture buffers hold a full frame.
REQ-007 fft_start  out  1  one-cycle pulse; launch 4-channel FFT.
REQ-008 fft_done  in  1  one-cycle pulse; FFT RAMs written.
REQ-009 detect_start  out  1  one-cycle pulse; launch frequency detection.
REQ-010 detect_done  out  1  level to weighting block, held high from maxbin valid until wb_done.
REQ-011 maxbin_in  in  10  peak bin from frequency detector, valid with maxbin_valid.
REQ-012 maxbin_valid  in  1  one-cycle pulse from frequency detector.
REQ-013 maxbin  out  10  registered maxbin, drives FFT RAM read addresses.
REQ-014 wb_done  in  1  one-cycle pulse from weighting block.
REQ-015 wb_doa  in  8  signed DOA in degrees (-90..90), valid with wb_done.
REQ-016 rd_en  in  1  host pop request.
REQ-017 rd_data  out  18  head entry {doa[7:0], maxbin[9:0]}, valid when fifo_empty=0.
REQ-018 fifo_empty  out  1; fifo_count  out  5  entries held.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 err_timeout, err_overflow  out  1 each  sticky error flags.
REQ-021 clr_err  in  1  one-cycle pulse clears both error flags.

Function
REQ-022 States: IDLE, WAIT_FRAME, FFT, DETECT, WEIGHT, PUSH.
REQ-023 IDLE -> WAIT_FRAME when enable=1.
REQ-024 WAIT_FRAME: on frame_ready assert fft_start next cycle and go FFT; if enable=0 and no frame_ready, go IDLE. No watchdog in WAIT_FRAME.
REQ-025 FFT: on fft_done assert detect_start next cycle, go DETECT.
REQ-026 DETECT: on maxbin_valid register maxbin_in into maxbin, set detect_done=1 next cycle, go WEIGHT.
REQ-027 WEIGHT: on wb_done latch wb_doa, clear detect_done next cycle, go PUSH.
REQ-028 PUSH: one cycle; write {doa, maxbin} into FIFO; then WAIT_FRAME if enable=1, else IDLE.
REQ-029 Start pulses are exactly one cycle wide and issued once per frame.
REQ-030 frame_ready outside WAIT_FRAME is ignored (frame dropped, no flag).
REQ-031 Watchdog: 16-bit counter cleared on entry to FFT, DETECT, WEIGHT; increments each cycle in those states; at count = TIMEOUT-1 set err_timeout, drop detect_done, go WAIT_FRAME (or IDLE if enable=0), no FIFO write.
REQ-032 Completion event and watchdog expiry in the same cycle: completion wins.
REQ-033 FIFO: synchronous, first-word fall-through; rd_data shows head combinationally from storage.
REQ-034 rd_en with fifo_empty=1 is ignored; count stays 0.
REQ-035 PUSH with FIFO full and rd_en=0: new entry dropped, err_overflow set.
REQ-036 PUSH with FIFO full and rd_en=1: pop and push both succeed, count unchanged.
REQ-037 Pointers wrap modulo FIFO_DEPTH; fifo_count = 0..FIFO_DEPTH.
REQ-038 clr_err coincident with a new error: error flag remains set.
REQ-039 Latency frame_ready -> fft_start = 1 cycle; wb_done -> FIFO entry visible = 2 cycles.

Reset
REQ-040 On reset: state IDLE; fft_start, detect_start, detect_done, busy = 0; maxbin = 0; FIFO empty, count 0, rd_data = 0; error flags 0; watchdog 0.
REQ-041 Reset mid-frame aborts immediately; late fft_done/maxbin_valid/wb_done pulses after reset are ignored until their state is reached.

Verification
REQ-042 enable=1, frame_ready, fft_done, maxbin_valid(maxbin_in=37), wb_done(wb_doa=-45) -> one fft_start, one detect_start, detect_done high WEIGHT only, rd_data={8'hD3,10'd37}, count=1.
REQ-043 TIMEOUT=8, no fft_done after fft_start -> err_timeout=1 at 8th FFT cycle, state WAIT_FRAME, count unchanged; clr_err -> flag 0.
REQ-044 Five frames, no rd_en, depth 4 -> count=4, err_overflow=1, entries are frames 1-4 in order.
REQ-045 FIFO full, PUSH with rd_en=1 same cycle -> count stays 4, head advances, no overflow.
REQ-046 Reset asserted in WEIGHT -> detect_done=0, busy=0, FIFO empty next cycle; subsequent wb_done ignored.
REQ-047 enable dropped during DETECT -> frame completes, entry pushed, state IDLE, busy=0.
